tile_drawer: RTL and testbench
==============================

// Module: tile_drawer
// PURPOSE
//  Downstream of the tile lookup stage. Takes a tile origin (x, y) and a colour,
//  then sweeps an 8x8 pixel block into the VGA adapter's plot/x/y/colour port,
//  one pixel per clock in row-major order. Pixels outside the 160x120 screen are
//  clipped. The controller starts a draw with a single-cycle start pulse and
//  waits for done.
// PARAMETERS
//  TILE_BITS  3    log2 of tile edge; tile is 2^TILE_BITS square (8x8 => 64 px)
//  X_MAX      160  screen width; a pixel with x >= X_MAX is clipped
//  Y_MAX      120  screen height; a pixel with y >= Y_MAX is clipped
// PORTS
//  clock       in   1  system clock; all state changes on the rising edge
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  request a draw; sampled only in IDLE
//  x_in        in   8  tile origin x, from the tile LUT
//  y_in        in   7  tile origin y, from the tile LUT
//  colour_in   in   3  tile colour, from the tile LUT
//  x_out       out  8  pixel x to the VGA adapter
//  y_out       out  7  pixel y to the VGA adapter
//  colour_out  out  3  pixel colour to the VGA adapter
//  plot        out  1  VGA write enable; high only for valid in-screen pixels
//  busy        out  1  draw in progress
//  done        out  1  one-cycle pulse when the draw completes
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0, latched origin and colour=0.
//    All outputs are 0. Reset mid-draw abandons the tile immediately and
//    produces no done pulse.
//  - States:
//    - IDLE: wait for start.
//    - DRAW: emit pixels.
//    - FINISH: one cycle, then back to IDLE.
//  - IDLE, edge N, start=1:
//    - latch x_in, y_in and colour_in; cnt<=0; busy<=1; state<=DRAW.
//    - Inputs may change after edge N without effect.
//  - DRAW, each edge:
//    - pixel k = cnt: col = cnt[2:0], row = cnt[5:3].
//    - x_out <= x0+col; y_out <= y0+row; colour_out <= latched colour.
//    - plot <= in-screen(k); cnt <= cnt+1.
//    - When cnt==63, state <= FINISH.
//    - Pixel k is visible in the cycle after edge N+1+k: pixel 0 after N+1,
//      pixel 63 after N+64.
//  - FINISH, edge N+65: plot<=0, busy<=0, done<=1, state<=IDLE.
//    done is cleared at the next edge.
//  - All outputs are registered; there is no combinational path from input to
//    output.
//  - Width and clipping:
//    - Sums are formed 1 bit wider (9b x, 8b y).
//    - in-screen = (xsum < X_MAX) && (ysum < Y_MAX).
//    - A clipped pixel still takes its cycle: plot=0, x_out/y_out = low bits
//      of the sum.
//  - start while busy (DRAW or FINISH) is ignored; it is not queued.
//  - start in the IDLE cycle right after FINISH is accepted normally; done and
//    the new busy do not overlap.
//  - Throughput: 65 cycles per tile from accept to done; next accept at the
//    earliest 1 edge later.
//  - colour_out is held at its last value when plot=0; the VGA adapter ignores
//    it then.
// CONFIGURATION
//  TILE_DRAWER_ERASE_EN
//  - defined: adds input port erase (1 bit), sampled together with start in IDLE.
//    - erase=1: latched colour forced to 3'b000, so the tile is drawn black.
//    - Timing is identical to a normal draw.
//  - undefined: no erase port; colour is always colour_in latched at start.
// TESTING
//  - Reset values: reset=1 mid-run, then released -> x_out/y_out/colour_out/
//    plot/busy/done all 0, no plot for 10 idle cycles.
//  - Basic draw: start x_in=8, y_in=8, colour_in=3'b011 ->
//    - 64 plot cycles;
//    - first (8,8), ninth (8,9), last (15,15);
//    - colour 011 throughout; done at cycle 65, busy falls with it.
//  - Clipping: start x_in=156, y_in=116 -> 64 draw cycles, plot=1 only for
//    x in 156..159 and y in 116..119 (16 pixels); done still at cycle 65.
//  - Busy start: start during DRAW at pixel 20 with new x_in -> ignored,
//    sequence unchanged; start on the first IDLE cycle after done -> second
//    tile drawn.
//  - Reset mid-draw: reset at pixel 30 -> plot=0 and busy=0 asynchronously,
//    no done; a later start draws the full 64 pixels.
//  - ERASE_EN: erase=1, start x_in=0, y_in=0, colour_in=3'b100 -> 64 pixels
//    at (0..7, 0..7) with colour_out=000; erase=0 -> colour 100.

Source files
------------

// File: rtl/tile_drawer_if.sv
// Pixel-drawer port bundle between the tile controller and tile_drawer.
//  master : controller side (drives start/origin/colour, receives pixel stream)
//  slave  : tile_drawer side
//  start, x_in[7:0], y_in[6:0], colour_in[2:0]  request and tile attributes
//  erase                                        (TILE_DRAWER_ERASE_EN only) draw black
//  x_out[7:0], y_out[6:0], colour_out[2:0], plot  VGA adapter write port
//  busy, done                                   draw status
interface tile_drawer_if;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
`ifdef TILE_DRAWER_ERASE_EN
    logic       erase;
`endif
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
`ifdef TILE_DRAWER_ERASE_EN
        output erase,
`endif
        output start, x_in, y_in, colour_in,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
`ifdef TILE_DRAWER_ERASE_EN
        input  erase,
`endif
        input  start, x_in, y_in, colour_in,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/tile_drawer.sv
// Sweeps a 2^TILE_BITS square tile into the VGA adapter, one pixel per clock,
// row-major, clipping pixels outside the X_MAX x Y_MAX screen.
// Ports:
//  clock  system clock, rising edge
//  reset  asynchronous, active-high
//  bus    tile_drawer_if.slave: start/x_in/y_in/colour_in in,
//         x_out/y_out/colour_out/plot/busy/done out (all registered)
// Optional feature macro: TILE_DRAWER_ERASE_EN adds bus.erase, which forces
// the latched colour to black.
module tile_drawer #(
    parameter int unsigned TILE_BITS = 3,
    parameter int unsigned X_MAX     = 160,
    parameter int unsigned Y_MAX     = 120
) (
    input  logic          clock,
    input  logic          reset,
    tile_drawer_if.slave  bus
);

    localparam int unsigned CNT_W = 2 * TILE_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FINISH
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           x0;
    logic [6:0]           y0;
    logic [2:0]           colour;

    logic [7:0]           x_r;
    logic [6:0]           y_r;
    logic [2:0]           colour_r;
    logic                 plot_r;
    logic                 busy_r;
    logic                 done_r;

    logic [TILE_BITS-1:0] col;
    logic [TILE_BITS-1:0] row;
    logic [8:0]           xsum;
    logic [7:0]           ysum;
    logic                 in_screen;

    // Pixel address for the current count; sums carry one extra bit so the
    // clip test sees coordinates past the 8/7-bit port range.
    always_comb begin
        col       = cnt[TILE_BITS-1:0];
        row       = cnt[CNT_W-1:TILE_BITS];
        xsum      = {1'b0, x0} + 9'(col);
        ysum      = {1'b0, y0} + 8'(row);
        in_screen = (xsum < 9'(X_MAX)) && (ysum < 8'(Y_MAX));
    end

    // Control FSM with registered pixel outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            x0       <= '0;
            y0       <= '0;
            colour   <= '0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    plot_r <= 1'b0;
                    if (bus.start) begin
                        x0     <= bus.x_in;
                        y0     <= bus.y_in;
`ifdef TILE_DRAWER_ERASE_EN
                        colour <= bus.erase ? 3'b000 : bus.colour_in;
`else
                        colour <= bus.colour_in;
`endif
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= DRAW;
                    end
                end
                DRAW: begin
                    // Clipped pixels still spend their cycle, with plot low.
                    x_r      <= xsum[7:0];
                    y_r      <= ysum[6:0];
                    colour_r <= colour;
                    plot_r   <= in_screen;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    plot_r <= 1'b0;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x_out      = x_r;
    assign bus.y_out      = y_r;
    assign bus.colour_out = colour_r;
    assign bus.plot       = plot_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_tile_drawer.sv
// Directed bench for tile_drawer: table of tiles with hand-computed plot
// counts plus a per-pixel geometric model, and hand-written reset sequences.
module tb_tile_drawer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    tile_drawer_if td_if ();

    tile_drawer dut (
        .clock (clock),
        .reset (reset),
        .bus   (td_if)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int cap_x [64];
    int cap_y [64];

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         plots;     // expected number of in-screen pixels
        int         poke_k;    // pixel index at which a start is attempted (-1: none)
        bit         b2b;       // issue on the first IDLE cycle after previous done
    } vec_t;

    vec_t tab [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        td_if.start     = 1'b1;
        td_if.x_in      = x;
        td_if.y_in      = y;
        td_if.colour_in = c;
        @(negedge clock);
        td_if.start     = 1'b0;
        td_if.x_in      = ~x;
        td_if.y_in      = ~y;
        td_if.colour_in = ~c;
        chk("accept_busy", int'(td_if.busy), 1);
        chk("accept_plot", int'(td_if.plot), 0);
        chk("accept_done", int'(td_if.done), 0);
    endtask

    // Checks all 64 pixels and the done cycle; returns at the negedge after done rises.
    task automatic sweep(input logic [7:0] x, input logic [6:0] y, input logic [2:0] ec,
                         input int poke_k, input int exp_plots);
        int xs, ys, nplot;
        bit ep;
        nplot = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            td_if.start = 1'b0;
            xs = int'(x) + (k % 8);
            ys = int'(y) + (k / 8);
            ep = (xs < 160) && (ys < 120);
            cap_x[k] = int'(td_if.x_out);
            cap_y[k] = int'(td_if.y_out);
            if (td_if.plot) nplot++;
            chk($sformatf("pix%0d_x", k), int'(td_if.x_out), xs % 256);
            chk($sformatf("pix%0d_y", k), int'(td_if.y_out), ys % 128);
            chk($sformatf("pix%0d_plot", k), int'(td_if.plot), int'(ep));
            chk($sformatf("pix%0d_colour", k), int'(td_if.colour_out), int'(ec));
            chk($sformatf("pix%0d_busy", k), int'(td_if.busy), 1);
            chk($sformatf("pix%0d_done", k), int'(td_if.done), 0);
            if (k == poke_k) begin
                td_if.start = 1'b1;
                td_if.x_in  = x + 8'd40;
                td_if.y_in  = 7'd3;
            end
        end
        @(negedge clock);
        td_if.start = 1'b0;
        chk("plot_count", nplot, exp_plots);
        chk("done_pulse", int'(td_if.done), 1);
        chk("done_busy", int'(td_if.busy), 0);
        chk("done_plot", int'(td_if.plot), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tab[0] = '{x: 8'd8,   y: 7'd8,   c: 3'b011, plots: 64, poke_k: -1, b2b: 1'b0};
        tab[1] = '{x: 8'd156, y: 7'd116, c: 3'b101, plots: 16, poke_k: 20, b2b: 1'b0};
        tab[2] = '{x: 8'd155, y: 7'd119, c: 3'b111, plots: 5,  poke_k: -1, b2b: 1'b1};
        tab[3] = '{x: 8'd250, y: 7'd5,   c: 3'b010, plots: 0,  poke_k: -1, b2b: 1'b1};
        tab[4] = '{x: 8'd159, y: 7'd0,   c: 3'b110, plots: 8,  poke_k: -1, b2b: 1'b0};
        tab[5] = '{x: 8'd0,   y: 7'd112, c: 3'b001, plots: 64, poke_k: -1, b2b: 1'b1};

        td_if.start     = 1'b0;
        td_if.x_in      = '0;
        td_if.y_in      = '0;
        td_if.colour_in = '0;
`ifdef TILE_DRAWER_ERASE_EN
        td_if.erase     = 1'b0;
`endif

        // Reset values and quiet idle.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_x", int'(td_if.x_out), 0);
        chk("rst_y", int'(td_if.y_out), 0);
        chk("rst_colour", int'(td_if.colour_out), 0);
        chk("rst_plot", int'(td_if.plot), 0);
        chk("rst_busy", int'(td_if.busy), 0);
        chk("rst_done", int'(td_if.done), 0);
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (td_if.plot || td_if.busy) n++;
        end
        chk("idle_quiet", n, 0);

        // Table of tiles.
        for (int i = 0; i < 6; i++) begin
            if (!tab[i].b2b) begin
                @(negedge clock);
                chk($sformatf("t%0d_done_clear", i), int'(td_if.done), 0);
            end
            issue(tab[i].x, tab[i].y, tab[i].c);
            sweep(tab[i].x, tab[i].y, tab[i].c, tab[i].poke_k, tab[i].plots);
            if (i == 0) begin
                chk("basic_first_x", cap_x[0], 8);
                chk("basic_first_y", cap_y[0], 8);
                chk("basic_ninth_x", cap_x[8], 8);
                chk("basic_ninth_y", cap_y[8], 9);
                chk("basic_last_x", cap_x[63], 15);
                chk("basic_last_y", cap_y[63], 15);
            end
        end
        @(negedge clock);
        chk("tail_done_clear", int'(td_if.done), 0);
        chk("tail_busy", int'(td_if.busy), 0);

        // Reset mid-draw at pixel 30.
        issue(8'd20, 7'd30, 3'b110);
        repeat (31) @(negedge clock);
        chk("mid_plot_before", int'(td_if.plot), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_plot", int'(td_if.plot), 0);
        chk("mid_rst_busy", int'(td_if.busy), 0);
        chk("mid_rst_done", int'(td_if.done), 0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        repeat (70) begin
            @(negedge clock);
            if (td_if.done || td_if.plot || td_if.busy) n++;
        end
        chk("mid_no_done", n, 0);
        issue(8'd20, 7'd30, 3'b110);
        sweep(8'd20, 7'd30, 3'b110, -1, 64);

`ifdef TILE_DRAWER_ERASE_EN
        @(negedge clock);
        td_if.erase = 1'b1;
        issue(8'd0, 7'd0, 3'b100);
        td_if.erase = 1'b0;
        sweep(8'd0, 7'd0, 3'b000, -1, 64);
        @(negedge clock);
        issue(8'd0, 7'd0, 3'b100);
        sweep(8'd0, 7'd0, 3'b100, -1, 64);
`endif

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
